// File: rtl/rc4_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// rc4_ctrl_pkg
//   Shared types and constants for the RC4 key-search sequencer.
//   - state_t : sequencer states (ST_ERROR exists only with RC4_WATCHDOG_EN)
//   - phase_t : which loop FSM currently owns the single-port S RAM
//   - S RAM geometry and the printable-character set the PRGA loop accepts
//   Optional feature macro: RC4_WATCHDOG_EN (adds the ERROR state).
// ---------------------------------------------------------------------------
package rc4_ctrl_pkg;

    localparam int S_ADDR_W = 8;
    localparam int S_DATA_W = 8;

    // Decoded bytes outside {CHAR_SPACE, CHAR_A..CHAR_Z} make the PRGA loop
    // raise run_again.
    localparam logic [7:0] CHAR_SPACE = 8'd32;
    localparam logic [7:0] CHAR_A     = 8'd97;
    localparam logic [7:0] CHAR_Z     = 8'd122;

    typedef enum logic [1:0] {
        PH_NONE = 2'd0,
        PH_INIT = 2'd1,
        PH_KSA  = 2'd2,
        PH_PRGA = 2'd3
    } phase_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START_INIT,
        ST_WAIT_INIT,
        ST_START_KSA,
        ST_WAIT_KSA,
        ST_START_PRGA,
        ST_WAIT_PRGA,
        ST_NEXT_KEY,
        ST_FOUND,
        ST_EXHAUSTED
`ifdef RC4_WATCHDOG_EN
        ,
        ST_ERROR
`endif
    } state_t;

endpackage

// File: rtl/rc4_s_mem_mux.sv
// ---------------------------------------------------------------------------
// rc4_s_mem_mux
//   Phase-selected 3:1 mux onto the single S RAM port. Only the current
//   owner's address/data/write-enable reach the RAM; PH_NONE parks the port
//   at address 0 with writes disabled.
//   Ports:
//     phase_i                       owner select (registered in the top)
//     init_/ksa_/prga_addr_i  [8]   per-loop RAM address
//     init_/ksa_/prga_data_i  [8]   per-loop write data
//     init_/ksa_/prga_wren_i        per-loop write enable
//     s_address_o/s_data_o/s_wren_o muxed RAM port
// ---------------------------------------------------------------------------
module rc4_s_mem_mux
    import rc4_ctrl_pkg::*;
(
    input  phase_t              phase_i,
    input  logic [S_ADDR_W-1:0] init_addr_i,
    input  logic [S_DATA_W-1:0] init_data_i,
    input  logic                init_wren_i,
    input  logic [S_ADDR_W-1:0] ksa_addr_i,
    input  logic [S_DATA_W-1:0] ksa_data_i,
    input  logic                ksa_wren_i,
    input  logic [S_ADDR_W-1:0] prga_addr_i,
    input  logic [S_DATA_W-1:0] prga_data_i,
    input  logic                prga_wren_i,
    output logic [S_ADDR_W-1:0] s_address_o,
    output logic [S_DATA_W-1:0] s_data_o,
    output logic                s_wren_o
);

    always_comb begin
        s_address_o = '0;
        s_data_o    = '0;
        s_wren_o    = 1'b0;
        case (phase_i)
            PH_INIT: begin
                s_address_o = init_addr_i;
                s_data_o    = init_data_i;
                s_wren_o    = init_wren_i;
            end
            PH_KSA: begin
                s_address_o = ksa_addr_i;
                s_data_o    = ksa_data_i;
                s_wren_o    = ksa_wren_i;
            end
            PH_PRGA: begin
                s_address_o = prga_addr_i;
                s_data_o    = prga_data_i;
                s_wren_o    = prga_wren_i;
            end
            default: ; // PH_NONE: port parked, no writes
        endcase
    end

endmodule

// File: rtl/rc4_key_search_ctrl.sv
// ---------------------------------------------------------------------------
// rc4_key_search_ctrl
//   Top-level sequencer for the RC4 brute-force key search. For each
//   candidate key it runs the S-init, KSA and PRGA loop FSMs in order, hands
//   S RAM ownership to exactly one loop at a time, steps the key on
//   run_again and reports the key on finish_prga.
//   Ports:
//     clk, reset_n                 clock, synchronous active-low reset
//     start                        begin search (ignored while busy)
//     start_init/ksa/prga          one-cycle start pulses to the loop FSMs
//     finish_init/ksa/prga         done strobes from the loop FSMs
//     run_again                    PRGA: current key decoded to garbage
//     init_/ksa_/prga_addr/data/wren  per-loop S RAM requests
//     s_address, s_data, s_wren    muxed S RAM port
//     secret_key [KEY_WIDTH]       current candidate key
//     phase [2]                    S RAM owner (0 none, 1 init, 2 ksa, 3 prga)
//     busy                         search in progress
//     key_found, key_exhausted     sticky result flags
//     wdog_error                   sticky phase timeout
//   Optional feature macro: RC4_WATCHDOG_EN adds a per-phase timeout of
//   WDOG_CYCLES clocks; without it wdog_error is tied low.
// ---------------------------------------------------------------------------
module rc4_key_search_ctrl
    import rc4_ctrl_pkg::*;
#(
    parameter int unsigned          KEY_WIDTH = 24,
    parameter logic [KEY_WIDTH-1:0] KEY_START = '0,
    parameter logic [KEY_WIDTH-1:0] KEY_LAST  = 24'h3FFFFF,
    parameter int unsigned          KEY_STEP  = 1
`ifdef RC4_WATCHDOG_EN
    ,
    parameter int unsigned          WDOG_CYCLES = 4096
`endif
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    output logic                 start_init,
    output logic                 start_ksa,
    output logic                 start_prga,
    input  logic                 finish_init,
    input  logic                 finish_ksa,
    input  logic                 finish_prga,
    input  logic                 run_again,
    input  logic [S_ADDR_W-1:0]  init_addr,
    input  logic [S_DATA_W-1:0]  init_data,
    input  logic                 init_wren,
    input  logic [S_ADDR_W-1:0]  ksa_addr,
    input  logic [S_DATA_W-1:0]  ksa_data,
    input  logic                 ksa_wren,
    input  logic [S_ADDR_W-1:0]  prga_addr,
    input  logic [S_DATA_W-1:0]  prga_data,
    input  logic                 prga_wren,
    output logic [S_ADDR_W-1:0]  s_address,
    output logic [S_DATA_W-1:0]  s_data,
    output logic                 s_wren,
    output logic [KEY_WIDTH-1:0] secret_key,
    output logic [1:0]           phase,
    output logic                 busy,
    output logic                 key_found,
    output logic                 key_exhausted,
    output logic                 wdog_error
);

    // Key arithmetic is done one bit wider so key + step can never wrap.
    localparam logic [KEY_WIDTH:0] STEP_W = (KEY_WIDTH + 1)'(KEY_STEP);
    localparam logic [KEY_WIDTH:0] LAST_W = {1'b0, KEY_LAST};

    state_t                 state_q;
    phase_t                 phase_q;
    logic [KEY_WIDTH-1:0]   key_q;
    logic                   start_init_q;
    logic                   start_ksa_q;
    logic                   start_prga_q;
    logic                   busy_q;
    logic                   found_q;
    logic                   exhausted_q;
    logic                   key_is_last;

    // The current key is the last one when stepping would pass KEY_LAST.
    assign key_is_last = (({1'b0, key_q} + STEP_W) > LAST_W);

`ifdef RC4_WATCHDOG_EN
    localparam logic [15:0] WDOG_LAST = 16'(WDOG_CYCLES - 1);

    logic [15:0] wdog_cnt_q;
    logic        wdog_err_q;
    logic        in_wait;
    logic        wait_strobe;

    // A WAIT state is satisfied only by its own strobe; anything else counts
    // toward the timeout.
    always_comb begin
        in_wait     = 1'b0;
        wait_strobe = 1'b0;
        case (state_q)
            ST_WAIT_INIT: begin
                in_wait     = 1'b1;
                wait_strobe = finish_init;
            end
            ST_WAIT_KSA: begin
                in_wait     = 1'b1;
                wait_strobe = finish_ksa;
            end
            ST_WAIT_PRGA: begin
                in_wait     = 1'b1;
                wait_strobe = run_again | finish_prga;
            end
            default: ;
        endcase
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            phase_q      <= PH_NONE;
            key_q        <= KEY_START;
            start_init_q <= 1'b0;
            start_ksa_q  <= 1'b0;
            start_prga_q <= 1'b0;
            busy_q       <= 1'b0;
            found_q      <= 1'b0;
            exhausted_q  <= 1'b0;
`ifdef RC4_WATCHDOG_EN
            wdog_cnt_q   <= '0;
            wdog_err_q   <= 1'b0;
`endif
        end else begin
            // Start pulses are set on entry to START_x and last one cycle.
            start_init_q <= 1'b0;
            start_ksa_q  <= 1'b0;
            start_prga_q <= 1'b0;

            case (state_q)
                ST_IDLE, ST_FOUND, ST_EXHAUSTED
`ifdef RC4_WATCHDOG_EN
                , ST_ERROR
`endif
                : begin
                    if (start) begin
                        busy_q  <= 1'b1;
                        state_q <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    key_q        <= KEY_START;
                    found_q      <= 1'b0;
                    exhausted_q  <= 1'b0;
`ifdef RC4_WATCHDOG_EN
                    wdog_err_q   <= 1'b0;
`endif
                    start_init_q <= 1'b1;
                    phase_q      <= PH_INIT;
                    state_q      <= ST_START_INIT;
                end

                ST_START_INIT: begin
`ifdef RC4_WATCHDOG_EN
                    wdog_cnt_q <= '0;
`endif
                    state_q <= ST_WAIT_INIT;
                end

                ST_WAIT_INIT: begin
                    if (finish_init) begin
                        start_ksa_q <= 1'b1;
                        phase_q     <= PH_KSA;
                        state_q     <= ST_START_KSA;
                    end
                end

                ST_START_KSA: begin
`ifdef RC4_WATCHDOG_EN
                    wdog_cnt_q <= '0;
`endif
                    state_q <= ST_WAIT_KSA;
                end

                ST_WAIT_KSA: begin
                    if (finish_ksa) begin
                        start_prga_q <= 1'b1;
                        phase_q      <= PH_PRGA;
                        state_q      <= ST_START_PRGA;
                    end
                end

                ST_START_PRGA: begin
`ifdef RC4_WATCHDOG_EN
                    wdog_cnt_q <= '0;
`endif
                    state_q <= ST_WAIT_PRGA;
                end

                ST_WAIT_PRGA: begin
                    // run_again wins over a simultaneous finish_prga.
                    if (run_again) begin
                        phase_q <= PH_NONE;
                        state_q <= ST_NEXT_KEY;
                    end else if (finish_prga) begin
                        found_q <= 1'b1;
                        busy_q  <= 1'b0;
                        phase_q <= PH_NONE;
                        state_q <= ST_FOUND;
                    end
                end

                ST_NEXT_KEY: begin
                    if (key_is_last) begin
                        exhausted_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= ST_EXHAUSTED;
                    end else begin
                        key_q        <= key_q + KEY_WIDTH'(KEY_STEP);
                        start_init_q <= 1'b1;
                        phase_q      <= PH_INIT;
                        state_q      <= ST_START_INIT;
                    end
                end

                default: begin
                    phase_q <= PH_NONE;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase

`ifdef RC4_WATCHDOG_EN
            // Overrides the WAIT-state hold above when the phase stalls.
            if (in_wait && !wait_strobe) begin
                if (wdog_cnt_q == WDOG_LAST) begin
                    wdog_err_q <= 1'b1;
                    busy_q     <= 1'b0;
                    phase_q    <= PH_NONE;
                    state_q    <= ST_ERROR;
                end else begin
                    wdog_cnt_q <= wdog_cnt_q + 16'd1;
                end
            end
`endif
        end
    end

    rc4_s_mem_mux u_s_mem_mux (
        .phase_i     (phase_q),
        .init_addr_i (init_addr),
        .init_data_i (init_data),
        .init_wren_i (init_wren),
        .ksa_addr_i  (ksa_addr),
        .ksa_data_i  (ksa_data),
        .ksa_wren_i  (ksa_wren),
        .prga_addr_i (prga_addr),
        .prga_data_i (prga_data),
        .prga_wren_i (prga_wren),
        .s_address_o (s_address),
        .s_data_o    (s_data),
        .s_wren_o    (s_wren)
    );

    assign start_init    = start_init_q;
    assign start_ksa     = start_ksa_q;
    assign start_prga    = start_prga_q;
    assign secret_key    = key_q;
    assign phase         = phase_q;
    assign busy          = busy_q;
    assign key_found     = found_q;
    assign key_exhausted = exhausted_q;
`ifdef RC4_WATCHDOG_EN
    assign wdog_error    = wdog_err_q;
`else
    assign wdog_error    = 1'b0;
`endif

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_rc4_key_search_ctrl
//   Drives the sequencer with randomized loop-FSM responses. A per-key table
//   of decoded bytes decides which key succeeds; the expected key sequence
//   and result are computed by walking that table with the valid-character
//   rule and the key start/step/last parameters.
// ---------------------------------------------------------------------------
module tb_rc4_key_search_ctrl;
    import rc4_ctrl_pkg::*;

    localparam int KW = 24;

    typedef struct packed {
        logic          start_init;
        logic          start_ksa;
        logic          start_prga;
        logic [7:0]    s_address;
        logic [7:0]    s_data;
        logic          s_wren;
        logic [KW-1:0] secret_key;
        logic [1:0]    phase;
        logic          busy;
        logic          key_found;
        logic          key_exhausted;
        logic          wdog_error;
    } dut_out_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    logic finish_init = 1'b0;
    logic finish_ksa = 1'b0;
    logic finish_prga = 1'b0;
    logic run_again = 1'b0;
    logic [7:0] init_addr = 8'd0, ksa_addr = 8'd0, prga_addr = 8'd0;
    logic [7:0] init_data = 8'd0, ksa_data = 8'd0, prga_data = 8'd0;
    logic init_wren = 1'b1, ksa_wren = 1'b1, prga_wren = 1'b1;

    dut_out_t oa, ob, o;
    int       sel = 0;
    int       checks = 0;
    int       errors = 0;
    int       init_pulses = 0;
    logic [7:0] dec_byte [0:63];

    always #5 clk = ~clk;

    // Default parameters: key space from 0 with step 1.
    rc4_key_search_ctrl dut_a (
        .clk(clk), .reset_n(reset_n), .start(start),
        .start_init(oa.start_init), .start_ksa(oa.start_ksa), .start_prga(oa.start_prga),
        .finish_init(finish_init), .finish_ksa(finish_ksa), .finish_prga(finish_prga),
        .run_again(run_again),
        .init_addr(init_addr), .init_data(init_data), .init_wren(init_wren),
        .ksa_addr(ksa_addr), .ksa_data(ksa_data), .ksa_wren(ksa_wren),
        .prga_addr(prga_addr), .prga_data(prga_data), .prga_wren(prga_wren),
        .s_address(oa.s_address), .s_data(oa.s_data), .s_wren(oa.s_wren),
        .secret_key(oa.secret_key), .phase(oa.phase), .busy(oa.busy),
        .key_found(oa.key_found), .key_exhausted(oa.key_exhausted),
        .wdog_error(oa.wdog_error)
    );

    // Small key space with a stride, to reach exhaustion.
    rc4_key_search_ctrl #(.KEY_LAST(24'd5), .KEY_STEP(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start),
        .start_init(ob.start_init), .start_ksa(ob.start_ksa), .start_prga(ob.start_prga),
        .finish_init(finish_init), .finish_ksa(finish_ksa), .finish_prga(finish_prga),
        .run_again(run_again),
        .init_addr(init_addr), .init_data(init_data), .init_wren(init_wren),
        .ksa_addr(ksa_addr), .ksa_data(ksa_data), .ksa_wren(ksa_wren),
        .prga_addr(prga_addr), .prga_data(prga_data), .prga_wren(prga_wren),
        .s_address(ob.s_address), .s_data(ob.s_data), .s_wren(ob.s_wren),
        .secret_key(ob.secret_key), .phase(ob.phase), .busy(ob.busy),
        .key_found(ob.key_found), .key_exhausted(ob.key_exhausted),
        .wdog_error(ob.wdog_error)
    );

`ifdef RC4_WATCHDOG_EN
    dut_out_t ow;
    rc4_key_search_ctrl #(.WDOG_CYCLES(16)) dut_w (
        .clk(clk), .reset_n(reset_n), .start(start),
        .start_init(ow.start_init), .start_ksa(ow.start_ksa), .start_prga(ow.start_prga),
        .finish_init(1'b0), .finish_ksa(finish_ksa), .finish_prga(finish_prga),
        .run_again(run_again),
        .init_addr(init_addr), .init_data(init_data), .init_wren(init_wren),
        .ksa_addr(ksa_addr), .ksa_data(ksa_data), .ksa_wren(ksa_wren),
        .prga_addr(prga_addr), .prga_data(prga_data), .prga_wren(prga_wren),
        .s_address(ow.s_address), .s_data(ow.s_data), .s_wren(ow.s_wren),
        .secret_key(ow.secret_key), .phase(ow.phase), .busy(ow.busy),
        .key_found(ow.key_found), .key_exhausted(ow.key_exhausted),
        .wdog_error(ow.wdog_error)
    );
`endif

    always_comb begin
        o = oa;
        if (sel == 1) o = ob;
`ifdef RC4_WATCHDOG_EN
        if (sel == 2) o = ow;
`endif
    end

    // Independent count of start_init pulse cycles on the selected DUT.
    always @(posedge clk) begin
        if (o.start_init) init_pulses <= init_pulses + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit msg_ok(input logic [7:0] b);
        return (b == CHAR_SPACE) || (b >= CHAR_A && b <= CHAR_Z);
    endfunction

    function automatic logic start_of(input int w);
        case (w)
            0:       return o.start_init;
            1:       return o.start_ksa;
            default: return o.start_prga;
        endcase
    endfunction

    // Only key n decodes to a valid character; n outside 0..63 means none.
    task automatic fill_table(input int n);
        for (int j = 0; j < 64; j++) begin
            if (j == n) begin
                int c;
                c = $urandom_range(0, 26);
                dec_byte[j] = (c == 0) ? CHAR_SPACE : 8'(96 + c);
            end else begin
                do dec_byte[j] = 8'($urandom); while (msg_ok(dec_byte[j]));
            end
        end
    endtask

    task automatic wait_start(input int w, input string tag);
        int n;
        n = 0;
        while (start_of(w) !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check_eq({tag, "_start_seen"}, 32'(start_of(w)), 1);
    endtask

    // Random delay inside the WAIT state, then a one-cycle done strobe.
    task automatic pulse(input int w);
        repeat ($urandom_range(0, 3)) tick();
        case (w)
            0:       finish_init = 1'b1;
            1:       finish_ksa  = 1'b1;
            default: finish_prga = 1'b1;
        endcase
        tick();
        finish_init = 1'b0;
        finish_ksa  = 1'b0;
        finish_prga = 1'b0;
    endtask

    task automatic check_owner(input int ph, input string tag);
        logic [7:0] ea, ed;
        case (ph)
            1:       begin ea = init_addr; ed = init_data; end
            2:       begin ea = ksa_addr;  ed = ksa_data;  end
            default: begin ea = prga_addr; ed = prga_data; end
        endcase
        check_eq({tag, "_phase"}, 32'(o.phase), ph);
        check_eq({tag, "_addr"},  32'(o.s_address), 32'(ea));
        check_eq({tag, "_data"},  32'(o.s_data), 32'(ed));
        check_eq({tag, "_wren"},  32'(o.s_wren), 1);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic run_search(input int step, input int last, input bit stray, input string tag);
        int keys[$];
        bit exp_found;
        int k;
        int base;

        // Reference: walk the key space until a key decodes to a valid char
        // or the next step would pass the last legal key.
        k = 0;
        exp_found = 1'b0;
        forever begin
            keys.push_back(k);
            if (msg_ok(dec_byte[k])) begin
                exp_found = 1'b1;
                break;
            end
            if (k + step > last) break;
            k += step;
        end

        init_addr = 8'($urandom);
        ksa_addr  = init_addr + 8'($urandom_range(1, 100));
        prga_addr = ksa_addr + 8'($urandom_range(1, 100));
        init_data = 8'($urandom);
        ksa_data  = 8'($urandom);
        prga_data = 8'($urandom);

        base = init_pulses;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq({tag, "_busy_load"}, 32'(o.busy), 1);
        tick();
        check_eq({tag, "_lat2"}, 32'(o.start_init), 1);
        check_eq({tag, "_flags_clr"}, 32'({o.key_found, o.key_exhausted}), 0);

        foreach (keys[i]) begin
            if (i > 0) wait_start(0, tag);
            check_owner(1, {tag, "_init"});
            tick();
            check_eq({tag, "_init_1cyc"}, 32'(o.start_init), 0);
            if (stray && i == 0) begin
                finish_ksa = 1'b1;
                start = 1'b1;
                tick();
                finish_ksa = 1'b0;
                start = 1'b0;
                tick();
                check_eq({tag, "_stray_phase"}, 32'(o.phase), 1);
                check_eq({tag, "_stray_noksa"}, 32'(o.start_ksa), 0);
                check_eq({tag, "_stray_busy"}, 32'(o.busy), 1);
            end
            pulse(0);
            wait_start(1, tag);
            check_owner(2, {tag, "_ksa"});
            check_eq({tag, "_ksa_key"}, 32'(o.secret_key), keys[i]);
            tick();
            check_eq({tag, "_ksa_key_hold"}, 32'(o.secret_key), keys[i]);
            pulse(1);
            wait_start(2, tag);
            check_owner(3, {tag, "_prga"});
            tick();
            repeat ($urandom_range(0, 3)) tick();
            if (msg_ok(dec_byte[keys[i]])) begin
                finish_prga = 1'b1;
            end else begin
                run_again = 1'b1;
                // Simultaneous finish must still count as a failed key.
                if ($urandom_range(0, 2) == 0) finish_prga = 1'b1;
            end
            tick();
            finish_prga = 1'b0;
            run_again   = 1'b0;
        end

        if (!exp_found) tick();
        check_eq({tag, "_busy_end"}, 32'(o.busy), 0);
        check_eq({tag, "_found"}, 32'(o.key_found), 32'(exp_found));
        check_eq({tag, "_exhausted"}, 32'(o.key_exhausted), 32'(!exp_found));
        check_eq({tag, "_key"}, 32'(o.secret_key), keys[keys.size() - 1]);
        check_eq({tag, "_phase_end"}, 32'(o.phase), 0);
        check_eq({tag, "_wren_end"}, 32'(o.s_wren), 0);
        repeat (4) tick();
        check_eq({tag, "_init_pulses"}, 32'(init_pulses - base), keys.size());
        $display("run %s: tried %0d keys, found=%0b key=%0h", tag, keys.size(), exp_found,
                 keys[keys.size() - 1]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        init_addr = 8'h11; ksa_addr = 8'h22; prga_addr = 8'h33;
        init_data = 8'h44; ksa_data = 8'h55; prga_data = 8'h66;
        repeat (3) tick();
        check_eq("rst_phase", 32'(o.phase), 0);
        check_eq("rst_busy", 32'(o.busy), 0);
        check_eq("rst_wren", 32'(o.s_wren), 0);
        check_eq("rst_addr", 32'(o.s_address), 0);
        check_eq("rst_data", 32'(o.s_data), 0);
        check_eq("rst_key", 32'(o.secret_key), 0);
        check_eq("rst_flags", 32'({o.key_found, o.key_exhausted, o.wdog_error}), 0);
        check_eq("rst_starts", 32'({o.start_init, o.start_ksa, o.start_prga}), 0);
        reset_n = 1'b1;
        tick();
        check_eq("idle_wren", 32'(o.s_wren), 0);

        // Keys 0..2 fail, key 3 succeeds.
        fill_table(3);
        run_search(1, 32'h3FFFFF, 1'b0, "t1");

        for (int r = 0; r < 5; r++) begin
            fill_table($urandom_range(0, 6));
            run_search(1, 32'h3FFFFF, (r == 1), "rand_a");
        end

        // Reset while the second key is in its KSA phase.
        fill_table(5);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wait_start(0, "t5");
            tick();
            pulse(0);
            wait_start(1, "t5");
            tick();
            if (i == 0) begin
                pulse(1);
                wait_start(2, "t5");
                tick();
                run_again = 1'b1;
                tick();
                run_again = 1'b0;
            end
        end
        check_eq("t5_key_before", 32'(o.secret_key), 1);
        reset_n = 1'b0;
        tick();
        check_eq("t5_phase", 32'(o.phase), 0);
        check_eq("t5_wren", 32'(o.s_wren), 0);
        check_eq("t5_busy", 32'(o.busy), 0);
        check_eq("t5_key", 32'(o.secret_key), 0);
        check_eq("t5_noprga", 32'(o.start_prga), 0);
        reset_n = 1'b1;
        tick();
        run_search(1, 32'h3FFFFF, 1'b0, "t5_restart");

        // Stride-2 instance over keys 0..5.
        do_reset();
        sel = 1;
        fill_table(-1);
        run_search(2, 5, 1'b0, "t2");
        for (int r = 0; r < 3; r++) begin
            fill_table($urandom_range(0, 5));
            run_search(2, 5, 1'b0, "rand_b");
        end

`ifdef RC4_WATCHDOG_EN
        do_reset();
        sel = 2;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_start(0, "t6");
        tick();
        repeat (15) tick();
        check_eq("t6_early", 32'(o.wdog_error), 0);
        tick();
        check_eq("t6_wdog", 32'(o.wdog_error), 1);
        check_eq("t6_busy", 32'(o.busy), 0);
        check_eq("t6_phase", 32'(o.phase), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check_eq("t6_clear", 32'(o.wdog_error), 0);
        check_eq("t6_busy2", 32'(o.busy), 1);
        $display("run t6: watchdog fired and cleared");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
